// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, status and result out.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic               start;
   logic [3:0]         select;
   logic [WIDTH-1:0]   value1;
   logic [WIDTH-1:0]   value2;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               div_zero;

   modport master (
      output start, select, value1, value2,
      input  busy, done, result, div_zero
   );

   modport slave (
      input  start, select, value1, value2,
      output busy, done, result, div_zero
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative signed multiply
// (shift-add) and signed restoring divide, one bit per cycle on operand magnitudes.
module seq_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input logic      clock,
   input logic      clear,
   seq_alu_if.slave bus
);
   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 2);

   localparam logic [3:0] OpAdd = 4'd1;
   localparam logic [3:0] OpSub = 4'd2;
   localparam logic [3:0] OpAnd = 4'd3;
   localparam logic [3:0] OpOr  = 4'd4;
   localparam logic [3:0] OpNeg = 4'd5;
   localparam logic [3:0] OpNot = 4'd6;
   localparam logic [3:0] OpShr = 4'd7;
   localparam logic [3:0] OpShl = 4'd8;
   localparam logic [3:0] OpRor = 4'd9;
   localparam logic [3:0] OpRol = 4'd10;
   localparam logic [3:0] OpDiv = 4'd11;
   localparam logic [3:0] OpMul = 4'd12;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFinish} state_e;

   state_e               state_q;
   logic                 is_div_q;
   logic                 neg_q;
   logic                 rneg_q;
   logic [CntW-1:0]      cnt_q;
   logic [WIDTH-1:0]     opnd_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 div_zero_q;
   logic [2*WIDTH-1:0]   result_q;

   logic [WIDTH-1:0]     a, b, a_mag, b_mag, simple;
   logic [SHW-1:0]       shamt, shamt_neg;
   logic [WIDTH:0]       mul_sum, div_shift;
   logic [WIDTH-1:0]     div_diff, quo_mag, rem_mag;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   mul_next, div_next, acc_step, final_res;

   always_comb begin
      a         = bus.value1;
      b         = bus.value2;
      a_mag     = a[WIDTH-1] ? -a : a;
      b_mag     = b[WIDTH-1] ? -b : b;
      shamt     = b[SHW-1:0];
      // Rotate via complementary shift; a zero amount degenerates to a | a.
      shamt_neg = -shamt;
      simple    = '0;
      case (bus.select)
         OpAdd:   simple = a + b;
         OpSub:   simple = a - b;
         OpAnd:   simple = a & b;
         OpOr:    simple = a | b;
         OpNeg:   simple = -a;
         OpNot:   simple = ~a;
         OpShr:   simple = a >> shamt;
         OpShl:   simple = a << shamt;
         OpRor:   simple = (a >> shamt) | (a << shamt_neg);
         OpRol:   simple = (a << shamt) | (a >> shamt_neg);
         default: simple = '0;
      endcase
   end

   // One iteration of either algorithm; FINISH reuses it for the last bit.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;
      div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
      acc_step  = is_div_q ? div_next : mul_next;
      quo_mag   = acc_step[WIDTH-1:0];
      rem_mag   = acc_step[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         final_res = {(rneg_q ? -rem_mag : rem_mag), (neg_q ? -quo_mag : quo_mag)};
      end else begin
         final_res = neg_q ? -acc_step : acc_step;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= StIdle;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         cnt_q      <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         result_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  div_zero_q <= 1'b0;
                  if (bus.select == OpMul) begin
                     acc_q    <= {{WIDTH{1'b0}}, b_mag};
                     opnd_q   <= a_mag;
                     neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                     rneg_q   <= 1'b0;
                     is_div_q <= 1'b0;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= StMul;
                  end else if (bus.select == OpDiv && b == '0) begin
                     result_q   <= '0;
                     div_zero_q <= 1'b1;
                     done_q     <= 1'b1;
                  end else if (bus.select == OpDiv) begin
                     acc_q    <= {{WIDTH{1'b0}}, a_mag};
                     opnd_q   <= b_mag;
                     neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                     rneg_q   <= a[WIDTH-1];
                     is_div_q <= 1'b1;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= StDiv;
                  end else begin
                     result_q <= {{WIDTH{1'b0}}, simple};
                     done_q   <= 1'b1;
                  end
               end
            end
            StMul, StDiv: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_q <= StFinish;
               end
            end
            StFinish: begin
               acc_q    <= acc_step;
               result_q <= final_res;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               cnt_q    <= '0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.div_zero = div_zero_q;
endmodule
